hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline hazard controller for the RV32I ID/EX stage. Compares decode-stage sources with the
//  rd/regWrite tags in ID/EX, EX/MEM and MEM/WB to generate ALU forwarding selects.
//  Inserts load-use bubbles, flushes IF/ID and ID/EX on taken branch/jal, and freezes the
//  pipeline during multi-cycle data-memory accesses. Keeps a saturating stall counter and a
//  sticky memory-timeout flag.
// PARAMETERS
//  FLUSH_CYC  2     cycles of flush after a taken redirect (1..3)
//  TIMEOUT    255   MEM_WAIT cycles before dmem_timeout sets
//  CNT_W      16    width of stall_cnt
// PORTS
//  CLK           in   1      clock, rising edge
//  RSTB          in   1      asynchronous reset, active-low
//  IFIDrs1       in   5      rs1 of instruction in decode
//  IFIDrs2       in   5      rs2 of instruction in decode
//  IFIDuse1      in   1      decode instruction reads rs1
//  IFIDuse2      in   1      decode instruction reads rs2
//  IDEXrs1       in   5      rs1 of instruction in EX
//  IDEXrs2       in   5      rs2 of instruction in EX
//  IDEXrd        in   5      rd in EX
//  IDEXmemRead   in   1      EX instruction is a load
//  EXMEMrd       in   5      rd in MEM
//  EXMEMregWrite in   1      MEM instruction writes rd
//  MEMWBrd       in   5      rd in WB
//  MEMWBregWrite in   1      WB instruction writes rd
//  branch_taken  in   1      EX resolved a taken branch/jal this cycle
//  dmem_req      in   1      MEM stage access in progress
//  dmem_ready    in   1      data memory completes access this cycle
//  fwdA          out  2      ALU A source: 00 regfile, 10 EX/MEM, 01 MEM/WB
//  fwdB          out  2      ALU B source, same encoding
//  pc_hold       out  1      PC keeps value
//  ifid_hold     out  1      IF/ID keeps value
//  idex_hold     out  1      ID/EX keeps value
//  exmem_hold    out  1      EX/MEM keeps value
//  idex_bubble   out  1      ID/EX loads NOP (regWrite, DmemWEB, DmemREB inactive)
//  ifid_flush    out  1      IF/ID loads NOP
//  stall_cnt     out  CNT_W  cycles with pc_hold=1, saturating
//  dmem_timeout  out  1      sticky error
// BEHAVIOUR
//  - Reset (RSTB=0, async): state RUN, flush count 0, wait count 0, stall_cnt 0, dmem_timeout 0.
//    All hold/flush/bubble outputs 0 and fwdA/fwdB 00 while in reset.
//  - Forwarding, combinational, always active: EX/MEM match (regWrite, rd!=0, rd==IDEXrsN) -> 10.
//    Otherwise MEM/WB match -> 01; otherwise 00. EX/MEM wins on a double match. x0 never forwarded.
//  - FSM states RUN, MEM_WAIT, FLUSH. Priority MEM_WAIT > redirect > load-use.
//  - RUN, dmem_req & !dmem_ready: assert all four holds this cycle and enter MEM_WAIT.
//  - RUN, branch_taken: assert ifid_flush and idex_bubble this cycle.
//    If FLUSH_CYC>1, go to FLUSH with count FLUSH_CYC-1.
//  - RUN, load-use (IDEXmemRead, IDEXrd!=0, IDEXrd equals a used IFIDrsN): assert pc_hold,
//    ifid_hold and idex_bubble for exactly 1 cycle; stay in RUN.
//  - MEM_WAIT: all holds stay 1 while !dmem_ready. branch_taken is ignored (EX frozen; the
//    redirect is re-presented after release). On dmem_ready, holds drop in that same cycle and
//    the state returns to RUN. Each wait cycle increments the wait count.
//    The wait count reaching TIMEOUT sets dmem_timeout; it clears only on reset.
//    The wait continues after timeout.
//  - FLUSH: ifid_flush=1 and idex_bubble=1, count decrements, RUN at 0. Load-use is masked.
//    A new branch_taken reloads the count. dmem_req while in FLUSH is not possible.
//  - stall_cnt increments each cycle pc_hold=1 and saturates at all-ones.
//  - Reset mid-MEM_WAIT or mid-FLUSH returns to RUN immediately with all outputs low.
// STRUCTURE
//  - Shared package pipe_pkg: state encoding, FWD_RF/FWD_EXMEM/FWD_MEMWB constants, NOP encoding.
//  - Sub-module fwd_unit (combinational forwarding compare), instanced twice (A and B).
//  - FSM, counters and the hold/flush decode sit in hazard_ctrl.
// TESTING
//  - IDEXrs1=5, EXMEMrd=5/regWrite=1, MEMWBrd=5/regWrite=1 -> fwdA=10; with EXMEMrd=0 -> fwdA=01.
//  - Load to x7 in EX, decode reads x7 (use1=1) -> 1-cycle pc_hold/ifid_hold/idex_bubble.
//    Same case with IDEXrd=0 -> no stall.
//  - branch_taken pulse with FLUSH_CYC=2 -> ifid_flush=1 for exactly 2 cycles, then RUN.
//  - dmem_req=1, dmem_ready low 3 cycles -> all holds 1 for 3 cycles, 0 on ready; stall_cnt += 3.
//  - TIMEOUT=4, ready never asserted -> dmem_timeout=1 after 4 cycles; stays 1 after ready.
//    Clears only on RSTB.
//  - RSTB pulled low mid-MEM_WAIT -> all outputs 0 asynchronously; state RUN after release.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: hazard FSM states, forwarding selects, writeback tags.
package pipe_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned FWD_W = 2;
  localparam int unsigned INSTR_W = 32;

  localparam logic [FWD_W-1:0] FWD_RF    = 2'b00;
  localparam logic [FWD_W-1:0] FWD_EXMEM = 2'b10;
  localparam logic [FWD_W-1:0] FWD_MEMWB = 2'b01;

  // addi x0, x0, 0: what a bubbled or flushed pipeline register holds
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FLUSH    = 2'd2
  } hz_state_e;

  // Destination tag carried by a later pipeline stage
  typedef struct packed {
    logic             wr;
    logic [REG_W-1:0] rd;
  } wb_tag_t;

endpackage

// File: rtl/fwd_unit.sv
// Forwarding compare for one ALU operand; the nearer producer (EX/MEM) wins.
module fwd_unit
  import pipe_pkg::*;
(
  input  logic [REG_W-1:0] rs,
  input  wb_tag_t          exmem,
  input  wb_tag_t          memwb,
  output logic [FWD_W-1:0] sel_c
);

  // x0 is never forwarded: a write to it is architecturally discarded
  always_comb begin
    sel_c = FWD_RF;
    if (exmem.wr && (exmem.rd != '0) && (exmem.rd == rs)) begin
      sel_c = FWD_EXMEM;
    end else if (memwb.wr && (memwb.rd != '0) && (memwb.rd == rs)) begin
      sel_c = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// RV32I ID/EX hazard controller: forwarding, load-use bubbles, redirect flush, memory freeze.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned FLUSH_CYC = 2,
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             RSTB,
  input  logic [REG_W-1:0] IFIDrs1,
  input  logic [REG_W-1:0] IFIDrs2,
  input  logic             IFIDuse1,
  input  logic             IFIDuse2,
  input  logic [REG_W-1:0] IDEXrs1,
  input  logic [REG_W-1:0] IDEXrs2,
  input  logic [REG_W-1:0] IDEXrd,
  input  logic             IDEXmemRead,
  input  logic [REG_W-1:0] EXMEMrd,
  input  logic             EXMEMregWrite,
  input  logic [REG_W-1:0] MEMWBrd,
  input  logic             MEMWBregWrite,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic [FWD_W-1:0] fwdA,
  output logic [FWD_W-1:0] fwdB,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             idex_hold,
  output logic             exmem_hold,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             dmem_timeout
);

  localparam int unsigned FLUSH_W = 2;
  localparam int unsigned WAIT_W  = $clog2(TIMEOUT + 1);

  hz_state_e          state_q, state_d;
  logic [FLUSH_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               timeout_q, timeout_d;

  wb_tag_t            exmem_tag, memwb_tag;
  logic [FWD_W-1:0]   fwd_a_c, fwd_b_c;
  logic               load_use_c, wait_inc_c;
  logic               pc_hold_c, ifid_hold_c, idex_hold_c, exmem_hold_c;
  logic               idex_bubble_c, ifid_flush_c;

  assign exmem_tag = '{wr: EXMEMregWrite, rd: EXMEMrd};
  assign memwb_tag = '{wr: MEMWBregWrite, rd: MEMWBrd};

  fwd_unit u_fwd_a (.rs(IDEXrs1), .exmem(exmem_tag), .memwb(memwb_tag), .sel_c(fwd_a_c));
  fwd_unit u_fwd_b (.rs(IDEXrs2), .exmem(exmem_tag), .memwb(memwb_tag), .sel_c(fwd_b_c));

  // Load in EX whose destination is read by the instruction in decode
  assign load_use_c = IDEXmemRead && (IDEXrd != '0) &&
                      ((IFIDuse1 && (IDEXrd == IFIDrs1)) || (IFIDuse2 && (IDEXrd == IFIDrs2)));

  // Next state and hold/flush decode; memory freeze outranks redirect outranks load-use
  always_comb begin
    state_d       = state_q;
    flush_cnt_d   = flush_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    timeout_d     = timeout_q;
    wait_inc_c    = 1'b0;
    pc_hold_c     = 1'b0;
    ifid_hold_c   = 1'b0;
    idex_hold_c   = 1'b0;
    exmem_hold_c  = 1'b0;
    idex_bubble_c = 1'b0;
    ifid_flush_c  = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (dmem_req && !dmem_ready) begin
          {pc_hold_c, ifid_hold_c, idex_hold_c, exmem_hold_c} = 4'b1111;
          wait_inc_c = 1'b1;
          state_d    = ST_MEM_WAIT;
        end else if (branch_taken) begin
          ifid_flush_c  = 1'b1;
          idex_bubble_c = 1'b1;
          if (FLUSH_CYC > 1) begin
            flush_cnt_d = FLUSH_W'(FLUSH_CYC - 1);
            state_d     = ST_FLUSH;
          end
        end else if (load_use_c) begin
          pc_hold_c     = 1'b1;
          ifid_hold_c   = 1'b1;
          idex_bubble_c = 1'b1;
        end
      end
      // EX is frozen here, so a branch_taken seen now is re-presented after release
      ST_MEM_WAIT: begin
        if (dmem_ready) begin
          wait_cnt_d = '0;
          state_d    = ST_RUN;
        end else begin
          {pc_hold_c, ifid_hold_c, idex_hold_c, exmem_hold_c} = 4'b1111;
          wait_inc_c = 1'b1;
        end
      end
      ST_FLUSH: begin
        ifid_flush_c  = 1'b1;
        idex_bubble_c = 1'b1;
        if (branch_taken) begin
          flush_cnt_d = FLUSH_W'(FLUSH_CYC - 1);
        end else begin
          flush_cnt_d = flush_cnt_q - FLUSH_W'(1);
          if (flush_cnt_d == '0) begin
            state_d = ST_RUN;
          end
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    // Wait count saturates at TIMEOUT; the error is sticky and the wait carries on
    if (wait_inc_c) begin
      if (wait_cnt_q != WAIT_W'(TIMEOUT)) begin
        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
      end
      if (wait_cnt_d == WAIT_W'(TIMEOUT)) begin
        timeout_d = 1'b1;
      end
    end
  end

  // Saturating count of cycles the PC is held
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (pc_hold_c && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State and counter registers
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= '0;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  // Control outputs are forced inactive for as long as reset is held
  assign fwdA         = RSTB ? fwd_a_c : FWD_RF;
  assign fwdB         = RSTB ? fwd_b_c : FWD_RF;
  assign pc_hold      = RSTB & pc_hold_c;
  assign ifid_hold    = RSTB & ifid_hold_c;
  assign idex_hold    = RSTB & idex_hold_c;
  assign exmem_hold   = RSTB & exmem_hold_c;
  assign idex_bubble  = RSTB & idex_bubble_c;
  assign ifid_flush   = RSTB & ifid_flush_c;
  assign stall_cnt    = stall_cnt_q;
  assign dmem_timeout = timeout_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (FLUSH_CYC=2, TIMEOUT=4, CNT_W=4).
module tb_hazard_ctrl;

  localparam int unsigned CNT_W = 4;

  localparam logic [5:0] C_NONE = 6'b000000;
  localparam logic [5:0] C_MEM  = 6'b111100;
  localparam logic [5:0] C_LU   = 6'b100010 | 6'b010000;
  localparam logic [5:0] C_FL   = 6'b000011;

  logic CLK, RSTB;
  logic [4:0] IFIDrs1, IFIDrs2, IDEXrs1, IDEXrs2, IDEXrd, EXMEMrd, MEMWBrd;
  logic IFIDuse1, IFIDuse2, IDEXmemRead, EXMEMregWrite, MEMWBregWrite;
  logic branch_taken, dmem_req, dmem_ready;
  logic [1:0] fwdA, fwdB;
  logic pc_hold, ifid_hold, idex_hold, exmem_hold, idex_bubble, ifid_flush;
  logic [CNT_W-1:0] stall_cnt;
  logic dmem_timeout;
  logic [5:0] ctl;

  int n_vec = 0;
  int n_err = 0;
  logic [CNT_W-1:0] exp_stall = '0;

  assign ctl = {pc_hold, ifid_hold, idex_hold, exmem_hold, idex_bubble, ifid_flush};

  hazard_ctrl #(.FLUSH_CYC(2), .TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RSTB(RSTB),
    .IFIDrs1(IFIDrs1), .IFIDrs2(IFIDrs2), .IFIDuse1(IFIDuse1), .IFIDuse2(IFIDuse2),
    .IDEXrs1(IDEXrs1), .IDEXrs2(IDEXrs2), .IDEXrd(IDEXrd), .IDEXmemRead(IDEXmemRead),
    .EXMEMrd(EXMEMrd), .EXMEMregWrite(EXMEMregWrite),
    .MEMWBrd(MEMWBrd), .MEMWBregWrite(MEMWBregWrite),
    .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .fwdA(fwdA), .fwdB(fwdB),
    .pc_hold(pc_hold), .ifid_hold(ifid_hold), .idex_hold(idex_hold), .exmem_hold(exmem_hold),
    .idex_bubble(idex_bubble), .ifid_flush(ifid_flush),
    .stall_cnt(stall_cnt), .dmem_timeout(dmem_timeout)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    IFIDrs1 = '0; IFIDrs2 = '0; IFIDuse1 = 1'b0; IFIDuse2 = 1'b0;
    IDEXrs1 = '0; IDEXrs2 = '0; IDEXrd = '0; IDEXmemRead = 1'b0;
    EXMEMrd = '0; EXMEMregWrite = 1'b0; MEMWBrd = '0; MEMWBregWrite = 1'b0;
    branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  task automatic test_reset();
    idle_inputs();
    RSTB = 1'b0;
    IDEXrs1 = 5'd5; EXMEMrd = 5'd5; EXMEMregWrite = 1'b1;
    dmem_req = 1'b1; branch_taken = 1'b1;
    tick(); tick(); settle();
    n_vec++; if (ctl !== C_NONE) begin n_err++; $display("FAIL reset_ctl got=%b exp=%b", ctl, C_NONE); end
    n_vec++; if (fwdA !== 2'b00) begin n_err++; $display("FAIL reset_fwdA got=%b exp=00", fwdA); end
    n_vec++; if (stall_cnt !== '0) begin n_err++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt); end
    n_vec++; if (dmem_timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout got=%b exp=0", dmem_timeout); end
    idle_inputs();
    RSTB = 1'b1;
    tick(); settle();
    n_vec++; if (ctl !== C_NONE) begin n_err++; $display("FAIL post_reset_ctl got=%b exp=%b", ctl, C_NONE); end
  endtask

  task automatic test_forwarding();
    // {rs1, rs2, exrd, exwr, wbrd, wbwr, fwdA, fwdB}
    logic [25:0] tv [7];
    logic [1:0] ea, eb;
    tv[0] = {5'd5,  5'd0,  5'd5,  1'b1, 5'd5,  1'b1, 2'b10, 2'b00};
    tv[1] = {5'd5,  5'd0,  5'd0,  1'b1, 5'd5,  1'b1, 2'b01, 2'b00};
    tv[2] = {5'd0,  5'd0,  5'd0,  1'b1, 5'd0,  1'b1, 2'b00, 2'b00};
    tv[3] = {5'd9,  5'd12, 5'd9,  1'b0, 5'd9,  1'b1, 2'b01, 2'b00};
    tv[4] = {5'd3,  5'd4,  5'd4,  1'b1, 5'd3,  1'b1, 2'b01, 2'b10};
    tv[5] = {5'd31, 5'd31, 5'd31, 1'b1, 5'd30, 1'b1, 2'b10, 2'b10};
    tv[6] = {5'd8,  5'd8,  5'd8,  1'b0, 5'd8,  1'b0, 2'b00, 2'b00};
    idle_inputs();
    for (int i = 0; i < 7; i++) begin
      {IDEXrs1, IDEXrs2, EXMEMrd, EXMEMregWrite, MEMWBrd, MEMWBregWrite, ea, eb} = tv[i];
      settle();
      n_vec++;
      if ({fwdA, fwdB} !== {ea, eb}) begin
        n_err++; $display("FAIL fwd_vec%0d got=%b/%b exp=%b/%b", i, fwdA, fwdB, ea, eb);
      end
      tick();
    end
    n_vec++; if (ctl !== C_NONE) begin n_err++; $display("FAIL fwd_ctl got=%b exp=%b", ctl, C_NONE); end
  endtask

  task automatic test_load_use();
    idle_inputs();
    IDEXmemRead = 1'b1; IDEXrd = 5'd7; IFIDrs1 = 5'd7; IFIDuse1 = 1'b1;
    settle();
    n_vec++; if (ctl !== C_LU) begin n_err++; $display("FAIL lu_rs1 got=%b exp=%b", ctl, C_LU); end
    exp_stall = sat_inc(exp_stall);
    tick();
    IDEXmemRead = 1'b0;
    settle();
    n_vec++; if (ctl !== C_NONE) begin n_err++; $display("FAIL lu_release got=%b exp=%b", ctl, C_NONE); end
    tick();
    IDEXmemRead = 1'b1; IDEXrd = 5'd0; IFIDrs1 = 5'd0;
    settle();
    n_vec++; if (ctl !== C_NONE) begin n_err++; $display("FAIL lu_x0 got=%b exp=%b", ctl, C_NONE); end
    tick();
    IDEXrd = 5'd7; IFIDrs1 = 5'd7; IFIDuse1 = 1'b0;
    settle();
    n_vec++; if (ctl !== C_NONE) begin n_err++; $display("FAIL lu_unused got=%b exp=%b", ctl, C_NONE); end
    tick();
    IFIDrs2 = 5'd7; IFIDuse2 = 1'b1;
    settle();
    n_vec++; if (ctl !== C_LU) begin n_err++; $display("FAIL lu_rs2 got=%b exp=%b", ctl, C_LU); end
    exp_stall = sat_inc(exp_stall);
    tick();
    idle_inputs();
    settle();
    n_vec++; if (stall_cnt !== exp_stall) begin n_err++; $display("FAIL lu_stall_cnt got=%0d exp=%0d", stall_cnt, exp_stall); end
  endtask

  task automatic test_branch_flush();
    idle_inputs();
    branch_taken = 1'b1;
    settle();
    n_vec++; if (ctl !== C_FL) begin n_err++; $display("FAIL br_c1 got=%b exp=%b", ctl, C_FL); end
    tick();
    branch_taken = 1'b0;
    IDEXmemRead = 1'b1; IDEXrd = 5'd4; IFIDrs1 = 5'd4; IFIDuse1 = 1'b1;
    settle();
    n_vec++; if (ctl !== C_FL) begin n_err++; $display("FAIL br_c2_lu_masked got=%b exp=%b", ctl, C_FL); end
    tick();
    settle();
    n_vec++; if (ctl !== C_LU) begin n_err++; $display("FAIL br_back_to_run got=%b exp=%b", ctl, C_LU); end
    exp_stall = sat_inc(exp_stall);
    tick();
    // redirect during FLUSH reloads the count
    idle_inputs();
    branch_taken = 1'b1;
    settle();
    n_vec++; if (ctl !== C_FL) begin n_err++; $display("FAIL br_rl_c1 got=%b exp=%b", ctl, C_FL); end
    tick();
    settle();
    n_vec++; if (ctl !== C_FL) begin n_err++; $display("FAIL br_rl_c2 got=%b exp=%b", ctl, C_FL); end
    tick();
    branch_taken = 1'b0;
    settle();
    n_vec++; if (ctl !== C_FL) begin n_err++; $display("FAIL br_rl_c3 got=%b exp=%b", ctl, C_FL); end
    tick();
    settle();
    n_vec++; if (ctl !== C_NONE) begin n_err++; $display("FAIL br_rl_end got=%b exp=%b", ctl, C_NONE); end
    // redirect outranks load-use
    IDEXmemRead = 1'b1; IDEXrd = 5'd4; IFIDrs1 = 5'd4; IFIDuse1 = 1'b1; branch_taken = 1'b1;
    settle();
    n_vec++; if (ctl !== C_FL) begin n_err++; $display("FAIL br_over_lu got=%b exp=%b", ctl, C_FL); end
    tick();
    idle_inputs();
    tick();
    settle();
    n_vec++; if (ctl !== C_NONE) begin n_err++; $display("FAIL br_prio_end got=%b exp=%b", ctl, C_NONE); end
  endtask

  task automatic test_mem_wait();
    idle_inputs();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    IDEXrs1 = 5'd6; EXMEMrd = 5'd6; EXMEMregWrite = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) branch_taken = 1'b1;
      settle();
      n_vec++; if (ctl !== C_MEM) begin n_err++; $display("FAIL mw_hold%0d got=%b exp=%b", i, ctl, C_MEM); end
      exp_stall = sat_inc(exp_stall);
      tick();
    end
    n_vec++; if (fwdA !== 2'b10) begin n_err++; $display("FAIL mw_fwdA got=%b exp=10", fwdA); end
    branch_taken = 1'b0; dmem_ready = 1'b1;
    settle();
    n_vec++; if (ctl !== C_NONE) begin n_err++; $display("FAIL mw_ready got=%b exp=%b", ctl, C_NONE); end
    tick();
    dmem_req = 1'b0; dmem_ready = 1'b0;
    settle();
    n_vec++; if (ctl !== C_NONE) begin n_err++; $display("FAIL mw_run got=%b exp=%b", ctl, C_NONE); end
    n_vec++; if (stall_cnt !== exp_stall) begin n_err++; $display("FAIL mw_stall_cnt got=%0d exp=%0d", stall_cnt, exp_stall); end
    n_vec++; if (dmem_timeout !== 1'b0) begin n_err++; $display("FAIL mw_no_timeout got=%b exp=0", dmem_timeout); end
  endtask

  task automatic test_timeout();
    idle_inputs();
    dmem_req = 1'b1;
    settle();
    for (int i = 0; i < 6; i++) begin
      n_vec++; if (ctl !== C_MEM) begin n_err++; $display("FAIL to_hold%0d got=%b exp=%b", i, ctl, C_MEM); end
      exp_stall = sat_inc(exp_stall);
      tick();
      settle();
      n_vec++;
      if (dmem_timeout !== (i >= 3)) begin
        n_err++; $display("FAIL to_flag%0d got=%b exp=%b", i, dmem_timeout, (i >= 3));
      end
    end
    dmem_ready = 1'b1;
    settle();
    n_vec++; if (ctl !== C_NONE) begin n_err++; $display("FAIL to_ready got=%b exp=%b", ctl, C_NONE); end
    tick();
    idle_inputs();
    settle();
    n_vec++; if (dmem_timeout !== 1'b1) begin n_err++; $display("FAIL to_sticky got=%b exp=1", dmem_timeout); end
    n_vec++; if (stall_cnt !== exp_stall) begin n_err++; $display("FAIL to_stall_cnt got=%0d exp=%0d", stall_cnt, exp_stall); end
  endtask

  task automatic test_stall_saturate();
    idle_inputs();
    dmem_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      settle();
      n_vec++; if (ctl !== C_MEM) begin n_err++; $display("FAIL sat_hold%0d got=%b exp=%b", i, ctl, C_MEM); end
      exp_stall = sat_inc(exp_stall);
      tick();
    end
    dmem_ready = 1'b1;
    tick();
    idle_inputs();
    settle();
    n_vec++; if (stall_cnt !== exp_stall) begin n_err++; $display("FAIL sat_stall_cnt got=%0d exp=%0d", stall_cnt, exp_stall); end
    n_vec++; if (stall_cnt !== 4'hF) begin n_err++; $display("FAIL sat_allones got=%0d exp=15", stall_cnt); end
  endtask

  task automatic test_reset_mid_op();
    idle_inputs();
    dmem_req = 1'b1;
    IDEXrs1 = 5'd6; EXMEMrd = 5'd6; EXMEMregWrite = 1'b1;
    tick(); tick();
    settle();
    RSTB = 1'b0;
    #1;
    exp_stall = '0;
    n_vec++; if (ctl !== C_NONE) begin n_err++; $display("FAIL rmw_ctl got=%b exp=%b", ctl, C_NONE); end
    n_vec++; if (fwdA !== 2'b00) begin n_err++; $display("FAIL rmw_fwdA got=%b exp=00", fwdA); end
    n_vec++; if (stall_cnt !== exp_stall) begin n_err++; $display("FAIL rmw_stall got=%0d exp=0", stall_cnt); end
    n_vec++; if (dmem_timeout !== 1'b0) begin n_err++; $display("FAIL rmw_timeout got=%b exp=0", dmem_timeout); end
    tick();
    dmem_req = 1'b0;
    settle();
    RSTB = 1'b1;
    #1;
    n_vec++; if (ctl !== C_NONE) begin n_err++; $display("FAIL rmw_run got=%b exp=%b", ctl, C_NONE); end
    tick();
    settle();
    n_vec++; if (fwdA !== 2'b10) begin n_err++; $display("FAIL rmw_fwd_back got=%b exp=10", fwdA); end
    n_vec++; if (stall_cnt !== exp_stall) begin n_err++; $display("FAIL rmw_stall_after got=%0d exp=%0d", stall_cnt, exp_stall); end
    // reset in the middle of a flush
    idle_inputs();
    branch_taken = 1'b1;
    tick();
    branch_taken = 1'b0;
    settle();
    RSTB = 1'b0;
    #1;
    n_vec++; if (ctl !== C_NONE) begin n_err++; $display("FAIL rfl_ctl got=%b exp=%b", ctl, C_NONE); end
    RSTB = 1'b1;
    #1;
    n_vec++; if (ctl !== C_NONE) begin n_err++; $display("FAIL rfl_run got=%b exp=%b", ctl, C_NONE); end
    tick();
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_flush();
    test_mem_wait();
    test_timeout();
    test_stall_saturate();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
